// File: rtl/md_alu_sequencer.sv
// md_alu_sequencer: multi-cycle MULTU/DIVU controller that time-shares the EX-stage ALU.
// Each iteration issues one ADD (multiply) or SUB (divide) on the ALU port. The carry or
// borrow is rebuilt from the operand and result MSBs. The block owns the HI/LO result registers.
//
// Optional feature macro: SIGNED_MD_EN
//   Adds signed MULT/DIV, selected by op[1]. Operands are reduced to magnitudes on accept.
//   A one-cycle FIX state then restores the result signs.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, op           request (sampled only in IDLE); op[0]=div, op[1]=signed
//   src_a, src_b        multiplicand/dividend and multiplier/divisor, captured on accept
//   alu_a, alu_b        ALU operands (zero outside ITER)
//   alu_ctrl            ALU control code (ALU_ADD outside ITER)
//   alu_result          combinational ALU result
//   busy                high whenever state != IDLE
//   done                one-cycle pulse; hi/lo valid
//   hi, lo              product[63:32]/[31:0] or remainder/quotient
module md_alu_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [2:0]  ALU_ADD  = 3'b010,
    parameter logic [2:0]  ALU_SUB  = 3'b110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
`ifdef SIGNED_MD_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic [WIDTH-1:0]   opnd, opnd_d;      // multiplicand or divisor
    logic               is_div, is_div_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   op_a;
    logic               carry, borrow;

`ifdef SIGNED_MD_EN
    logic               sgn, sgn_d;
    logic               neg_a, neg_a_d;
    logic               neg_b, neg_b_d;
`else
    logic               unused_op_sign;
    assign unused_op_sign = op[1];
`endif

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SIGNED_MD_EN
            sgn    <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            hi     <= hi_d;
            lo     <= lo_d;
            opnd   <= opnd_d;
            is_div <= is_div_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            done   <= done_d;
`ifdef SIGNED_MD_EN
            sgn    <= sgn_d;
            neg_a  <= neg_a_d;
            neg_b  <= neg_b_d;
`endif
        end
    end

    // Next-state, datapath update and ALU port drive
    always_comb begin
        state_d  = state;
        hi_d     = hi;
        lo_d     = lo;
        opnd_d   = opnd;
        is_div_d = is_div;
        cnt_d    = cnt;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        abs_a    = src_a;
        abs_b    = src_b;
        op_a     = '0;
        carry    = 1'b0;
        borrow   = 1'b0;
`ifdef SIGNED_MD_EN
        sgn_d    = sgn;
        neg_a_d  = neg_a;
        neg_b_d  = neg_b;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef SIGNED_MD_EN
                    sgn_d   = op[1];
                    neg_a_d = op[1] & src_a[WIDTH-1];
                    neg_b_d = op[1] & src_b[WIDTH-1];
                    abs_a   = neg_a_d ? -src_a : src_a;
                    abs_b   = neg_b_d ? -src_b : src_b;
`endif
                    state_d  = S_ITER;
                    cnt_d    = '0;
                    hi_d     = '0;
                    is_div_d = op[0];
                    if (op[0]) begin
                        lo_d   = abs_a;
                        opnd_d = abs_b;
                    end else begin
                        lo_d   = abs_b;
                        opnd_d = abs_a;
                    end
                end
            end

            S_ITER: begin
                cnt_d = cnt + CNT_W'(1);
                if (is_div) begin
                    // Restoring step: hi[31] is the 33rd bit of the shifted partial remainder
                    op_a     = {hi[WIDTH-2:0], lo[WIDTH-1]};
                    alu_a    = op_a;
                    alu_b    = opnd;
                    alu_ctrl = ALU_SUB;
                    borrow   = (~op_a[WIDTH-1] & opnd[WIDTH-1])
                             | (~(op_a[WIDTH-1] ^ opnd[WIDTH-1]) & alu_result[WIDTH-1]);
                    if (hi[WIDTH-1] | ~borrow) begin
                        hi_d = alu_result;
                        lo_d = {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = op_a;
                        lo_d = {lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add step: the 33-bit sum shifts right into {hi,lo}
                    alu_a    = hi;
                    alu_b    = opnd;
                    alu_ctrl = ALU_ADD;
                    carry    = (hi[WIDTH-1] & opnd[WIDTH-1])
                             | ((hi[WIDTH-1] | opnd[WIDTH-1]) & ~alu_result[WIDTH-1]);
                    if (lo[0]) begin
                        hi_d = {carry, alu_result[WIDTH-1:1]};
                        lo_d = {alu_result[0], lo[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi[WIDTH-1:1]};
                        lo_d = {hi[0], lo[WIDTH-1:1]};
                    end
                end
                if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIGNED_MD_EN
                    state_d = sgn ? S_FIX : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef SIGNED_MD_EN
            S_FIX: begin
                // Restore signs of the magnitude result
                if (!is_div) begin
                    if (neg_a ^ neg_b) begin
                        {hi_d, lo_d} = -{hi, lo};
                    end
                end else begin
                    if (neg_a ^ neg_b) begin
                        lo_d = -lo;
                    end
                    if (neg_a) begin
                        hi_d = -hi;
                    end
                end
                state_d = S_DONE;
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_md_alu_sequencer.sv
// Testbench for md_alu_sequencer. It models the ALU and drives directed and random requests.
// A scoreboard queue holds the expected hi/lo results and done cycles from an arithmetic reference.
module tb_md_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        busy, done;
    logic [31:0] hi, lo;

    md_alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Environment ALU
    assign alu_result = (alu_ctrl == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit is_signed_op(input logic [1:0] o);
`ifdef SIGNED_MD_EN
        return o[1];
`else
        return 1'b0 & o[1];
`endif
    endfunction

    // Reference: 64-bit arithmetic on the operand values
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, p, q, r;
        bit sg;
        sg = is_signed_op(o);
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        if (!o[0]) begin
            p = sa * sb;
            return 64'(p);
        end
        if (b == 32'd0) begin
            // Magnitude divide-by-zero gives all-ones quotient; signs restored afterwards
            return {a, (sg && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Must be called at a negedge; returns after the accept edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        exp_t e;
        logic [63:0] m;
        m   = model(o, a, b);
        lat = is_signed_op(o) ? 34 : 33;
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        e.due = ec + lat;
        exp_q.push_back(e);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int p1, input int p2, input bit chk_ctrl);
        int lat;
        issue(o, a, b, lat);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(k <= lat));
            if (chk_ctrl && k <= 32)
                chk("alu_ctrl_div_iter", 64'(alu_ctrl), 64'(3'b110));
            if (k == lat) begin
                chk("alu_a_idle", 64'(alu_a), 64'(0));
                chk("alu_b_idle", 64'(alu_b), 64'(0));
                chk("alu_ctrl_idle", 64'(alu_ctrl), 64'(3'b010));
            end
            start = ((k == p1) || (k == p2)) && (k <= lat);
            if (start) begin
                op    = 2'($urandom_range(0, 3));
                src_a = $urandom;
                src_b = $urandom;
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("done_cycle", 64'(ec), 64'(e.due));
                end
            end
        end
    end

    initial begin : stim
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        chk("rst_alu_b", 64'(alu_b), 64'(0));
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(3'b010));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 0, 0, 1'b1);
        run_op(2'b01, 32'h0000_1234, 32'd0, 0, 0, 1'b1);
        run_op(2'b00, 32'd3, 32'd4, 5, 33, 1'b0);

        // Reset mid-operation aborts without a done pulse
        issue(2'b00, 32'd1234, 32'd5678, lat);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_idle_busy", 64'(busy), 64'(0));

        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);

        // Randomized back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
                   int'($urandom_range(0, 36)), 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
